clock_set_ctrl: RTL

//   Time/date setting controller for the clock. Debounces two raw keys (MODE, INC), runs a
//   set-mode FSM that freezes the timekeeping chain and edits shadow copies of hour/minute/
//   day/month, then issues a one-cycle load strobe back into the counters. Drives the field

---
 rtl/clock_pkg.sv | 30 +++
 rtl/key_debounce.sv | 46 ++++
 rtl/clock_set_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock set-mode controller: FSM encoding, field codes,
// field widths and wrap limits.
package clock_pkg;

    typedef enum logic [2:0] {
        StRun,
        StSetHour,
        StSetMin,
        StSetDay,
        StSetMonth,
        StCommit
    } state_e;

    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;

    localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
    localparam logic [DAY_W-1:0]   DAY_MAX   = 5'd30;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd11;

    localparam logic [2:0] FIELD_NONE   = 3'd0;
    localparam logic [2:0] FIELD_HOUR   = 3'd1;
    localparam logic [2:0] FIELD_MINUTE = 3'd2;
    localparam logic [2:0] FIELD_DAY    = 3'd3;
    localparam logic [2:0] FIELD_MONTH  = 3'd4;

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchroniser, tick-sampled majority filter and a one-clk
// rising-edge press pulse.
module key_debounce #(
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_SAMPLES + 1);

    logic [1:0]             sync_q;
    logic [DEB_SAMPLES-1:0] shift_q;
    logic [CNT_W-1:0]       ones;
    logic                   level;
    logic                   level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            shift_q <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_raw};
            level_q <= level;
            if (tick) begin
                shift_q <= {shift_q[DEB_SAMPLES-2:0], sync_q[1]};
            end
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(DEB_SAMPLES); i++) begin
            ones = ones + CNT_W'(shift_q[i]);
        end
    end

    // Strict majority so a bouncing key that splits samples evenly stays released.
    assign level = (ones > CNT_W'(DEB_SAMPLES / 2));
    assign press = level & ~level_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time/date set-mode controller: edits shadow copies of hour/minute/day/month while the
// timekeeping chain is frozen, then loads them back with a one-clk strobe.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES   = 4,
    parameter int unsigned TIMEOUT_TICKS = 2048,
    parameter int unsigned BLINK_TICKS   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               key_mode,
    input  logic               key_inc,
    input  logic [HOUR_W-1:0]  cur_hour,
    input  logic [MIN_W-1:0]   cur_minute,
    input  logic [DAY_W-1:0]   cur_day,
    input  logic [MONTH_W-1:0] cur_month,
    output logic               run_en,
    output logic               load_stb,
    output logic [HOUR_W-1:0]  load_hour,
    output logic [MIN_W-1:0]   load_minute,
    output logic [DAY_W-1:0]   load_day,
    output logic [MONTH_W-1:0] load_month,
    output logic [2:0]         field_sel,
    output logic               blink,
    output logic               abort_stb
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS);
    localparam int unsigned BLK_W = $clog2(BLINK_TICKS);

    state_e state_q, state_d;

    logic mode_press, inc_press, any_press, in_set, timeout_hit, edit;

    logic [HOUR_W-1:0]  hour_q;
    logic [MIN_W-1:0]   minute_q;
    logic [DAY_W-1:0]   day_q;
    logic [MONTH_W-1:0] month_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [BLK_W-1:0]   blk_cnt_q;
    logic               blink_q;
    logic               abort_q;

    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .key_raw (key_mode),
        .press   (mode_press)
    );

    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .key_raw (key_inc),
        .press   (inc_press)
    );

    assign any_press = mode_press | inc_press;
    assign in_set    = (state_q == StSetHour) || (state_q == StSetMin) ||
                       (state_q == StSetDay)  || (state_q == StSetMonth);
    // A press on the expiring tick keeps the user in set mode.
    assign timeout_hit = in_set && tick && !any_press &&
                         (tmo_q == TMO_W'(TIMEOUT_TICKS - 1));
    // Mode wins over a coincident inc press.
    assign edit = in_set && inc_press && !mode_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:      if (mode_press) state_d = StSetHour;
            StSetHour:  if (mode_press) state_d = StSetMin;   else if (timeout_hit) state_d = StRun;
            StSetMin:   if (mode_press) state_d = StSetDay;   else if (timeout_hit) state_d = StRun;
            StSetDay:   if (mode_press) state_d = StSetMonth; else if (timeout_hit) state_d = StRun;
            StSetMonth: if (mode_press) state_d = StCommit;   else if (timeout_hit) state_d = StRun;
            StCommit:   state_d = StRun;
            default:    state_d = StRun;
        endcase
    end

    always_comb begin
        run_en    = (state_q == StRun) || (state_q == StCommit);
        load_stb  = (state_q == StCommit);
        field_sel = FIELD_NONE;
        unique case (state_q)
            StSetHour:  field_sel = FIELD_HOUR;
            StSetMin:   field_sel = FIELD_MINUTE;
            StSetDay:   field_sel = FIELD_DAY;
            StSetMonth: field_sel = FIELD_MONTH;
            default:    field_sel = FIELD_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_q   <= '0;
            minute_q <= '0;
            day_q    <= '0;
            month_q  <= '0;
        end else if (state_q == StRun && mode_press) begin
            hour_q   <= cur_hour;
            minute_q <= cur_minute;
            day_q    <= cur_day;
            month_q  <= cur_month;
        end else if (edit) begin
            unique case (state_q)
                StSetHour:  hour_q   <= (hour_q == HOUR_MAX)    ? '0 : hour_q + HOUR_W'(1);
                StSetMin:   minute_q <= (minute_q == MIN_MAX)   ? '0 : minute_q + MIN_W'(1);
                StSetDay:   day_q    <= (day_q == DAY_MAX)      ? '0 : day_q + DAY_W'(1);
                StSetMonth: month_q  <= (month_q == MONTH_MAX)  ? '0 : month_q + MONTH_W'(1);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= timeout_hit;
            if (!in_set || any_press || state_d != state_q) begin
                tmo_q     <= '0;
                blk_cnt_q <= '0;
                blink_q   <= 1'b0;
            end else if (tick) begin
                tmo_q <= tmo_q + TMO_W'(1);
                if (blk_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                    blk_cnt_q <= '0;
                    blink_q   <= ~blink_q;
                end else begin
                    blk_cnt_q <= blk_cnt_q + BLK_W'(1);
                end
            end
        end
    end

    assign load_hour   = hour_q;
    assign load_minute = minute_q;
    assign load_day    = day_q;
    assign load_month  = month_q;
    assign blink       = blink_q;
    assign abort_stb   = abort_q;

endmodule
